// File: rtl/jtopll_wrseq_pkg.sv
// Shared types and default timing constants for the OPLL write sequencer.
// Also used by bench models so expected gaps track the design defaults.
package jtopll_wrseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AWAIT,
        ST_DATA,
        ST_DWAIT
    } wrseq_state_e;

    localparam int unsigned OPLL_ADDR_WAIT = 12;
    localparam int unsigned OPLL_DATA_WAIT = 84;
    localparam int unsigned CNT_W          = 7;

endpackage

// File: rtl/jtopll_wrfifo.sv
// Small show-ahead synchronous FIFO holding {register, value} pairs.
module jtopll_wrfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_ONE;
            end
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/jtopll_wrseq.sv
// Queues {register, value} writes and issues them to the OPLL bus while
// honouring the address-to-data and data-to-address settling gaps in cen ticks.
module jtopll_wrseq
    import jtopll_wrseq_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_WAIT = OPLL_ADDR_WAIT,
    parameter int unsigned DATA_WAIT = OPLL_DATA_WAIT,
    parameter int unsigned SKIP_SAME = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cen_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [7:0]               in_reg_i,
    input  logic [7:0]               in_val_i,
    output logic                     write_o,
    output logic                     addr_o,
    output logic [7:0]               dout_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    if (ADDR_WAIT < 1 || ADDR_WAIT > 127) begin : gen_bad_addr_wait
        $error("jtopll_wrseq: ADDR_WAIT must be in 1..127");
    end
    if (DATA_WAIT < 1 || DATA_WAIT > 127) begin : gen_bad_data_wait
        $error("jtopll_wrseq: DATA_WAIT must be in 1..127");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("jtopll_wrseq: DEPTH must be a power of two in 2..16");
    end

    localparam logic [CNT_W-1:0] ALAST = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DLAST = CNT_W'(DATA_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wrseq_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       reg_q, reg_d, val_q, val_d, last_q, last_d, dout_q, dout_d;
    logic             last_vld_q, last_vld_d;
    logic             write_q, write_d, addr_q, addr_d, busy_q, busy_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]      fifo_rd;

    assign fifo_push = in_valid_i & ~fifo_full;

    jtopll_wrfifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({in_reg_i, in_val_i}),
        .dout_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reg_d      = reg_q;
        val_d      = val_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    reg_d    = fifo_rd[15:8];
                    val_d    = fifo_rd[7:0];
                    if (SKIP_SAME != 0 && last_vld_q && fifo_rd[15:8] == last_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                write_d    = 1'b1;
                addr_d     = 1'b0;
                dout_d     = reg_q;
                last_d     = reg_q;
                last_vld_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_AWAIT;
            end
            ST_AWAIT: begin
                if (cen_i) begin
                    if (cnt_q == ALAST) state_d = ST_DATA;
                    else                cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                write_d = 1'b1;
                addr_d  = 1'b1;
                dout_d  = val_q;
                cnt_d   = '0;
                state_d = ST_DWAIT;
            end
            ST_DWAIT: begin
                if (cen_i) begin
                    if (cnt_q == DLAST) state_d = ST_IDLE;
                    else                cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A push this cycle means the FIFO is non-empty next cycle.
        busy_d = (state_d != ST_IDLE) || !fifo_empty || fifo_push;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            reg_q      <= '0;
            val_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= 1'b0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready_o = ~fifo_full;
    assign write_o    = write_q;
    assign addr_o     = addr_q;
    assign dout_o     = dout_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Directed bench for jtopll_wrseq: strobe order, latency, settling gaps in cen
// ticks, address skipping, FIFO back-pressure, reset abort and cen stall.
module tb_jtopll_wrseq;
    import jtopll_wrseq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned tick;
        logic        a;
        logic [7:0]  d;
    } strobe_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen = 1'b0;
    logic          in_valid;
    logic [7:0]    in_reg, in_val;
    logic          in_ready, write, addr, busy;
    logic [7:0]    dout;
    logic [LW-1:0] level;
    logic          in_ready_b, write_b, addr_b, busy_b;
    logic [7:0]    dout_b;
    logic [LW-1:0] level_b;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   cyc = 0;
    int unsigned   ticks = 0;
    int unsigned   cen_div = 4;
    int unsigned   cen_cnt = 0;
    bit            cen_hold = 1'b0;
    int unsigned   max_level = 0;
    int unsigned   rdy_bad = 0;
    bit            saw_full = 1'b0;
    strobe_t       mon_q[$];
    strobe_t       mon0_q[$];

    jtopll_wrseq #(
        .DEPTH     (DEPTH),
        .ADDR_WAIT (OPLL_ADDR_WAIT),
        .DATA_WAIT (OPLL_DATA_WAIT),
        .SKIP_SAME (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cen_i      (cen),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_reg_i   (in_reg),
        .in_val_i   (in_val),
        .write_o    (write),
        .addr_o     (addr),
        .dout_o     (dout),
        .busy_o     (busy),
        .level_o    (level)
    );

    jtopll_wrseq #(
        .DEPTH     (DEPTH),
        .ADDR_WAIT (OPLL_ADDR_WAIT),
        .DATA_WAIT (OPLL_DATA_WAIT),
        .SKIP_SAME (0)
    ) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .cen_i      (cen),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_b),
        .in_reg_i   (in_reg),
        .in_val_i   (in_val),
        .write_o    (write_b),
        .addr_o     (addr_b),
        .dout_o     (dout_b),
        .busy_o     (busy_b),
        .level_o    (level_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cen_hold) begin
            cen = 1'b0;
        end else begin
            cen_cnt = (cen_cnt + 1) % cen_div;
            cen = (cen_cnt == 0);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cen) ticks <= ticks + 1;
    end

    // Samples 2 ns after the edge, so the test process sees results at negedge.
    always @(posedge clk) begin
        #2;
        if (write === 1'b1) mon_q.push_back('{cyc, ticks, addr, dout});
        if (write_b === 1'b1) mon0_q.push_back('{cyc, ticks, addr_b, dout_b});
        if (int'(level) > max_level) max_level = int'(level);
        if (level == DEPTH && in_ready === 1'b0) saw_full = 1'b1;
        if (in_ready !== (level != DEPTH)) rdy_bad++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_strobe(input string tag, input bit sel, input int idx,
                                input logic a, input logic [7:0] d);
        strobe_t s;
        s = sel ? mon0_q[idx] : mon_q[idx];
        check_val($sformatf("%s[%0d]", tag, idx), {23'd0, s.a, s.d}, {23'd0, a, d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
        mon0_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] r, input logic [7:0] v);
        in_valid = 1'b1;
        in_reg   = r;
        in_val   = v;
        for (int k = 0; k < 2000 && in_ready !== 1'b1; k++) @(negedge clk);
        if (in_ready !== 1'b1) check_val("push_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (mon_q.size() >= n) break;
            @(negedge clk);
        end
        check_val(tag, mon_q.size() >= n, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit, output int unsigned fall_tick);
        for (int k = 0; k < limit; k++) begin
            if (busy === 1'b0 && busy_b === 1'b0) break;
            @(negedge clk);
        end
        fall_tick = ticks;
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned fall;
        int unsigned c_d;
        logic [7:0]  vals[20];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_reg   = 8'h00;
        in_val   = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_write", {31'd0, write}, 32'd0);
        check_val("rst_addr", {31'd0, addr}, 32'd0);
        check_val("rst_dout", {24'd0, dout}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);

        // Single pair, cen every 4 clk
        do_reset();
        cen_div = 4;
        push(8'h10, 8'h55);
        in_valid = 1'b0;
        check_val("t1_level_n", 32'(level), 32'd1);
        check_val("t1_busy_n", {31'd0, busy}, 32'd1);
        check_val("t1_write_n", {31'd0, write}, 32'd0);
        @(negedge clk);
        check_val("t1_write_n1", {31'd0, write}, 32'd0);
        check_val("t1_level_n1", 32'(level), 32'd0);
        @(negedge clk);
        check_val("t1_astrobe", {23'd0, write, addr, dout}, {23'd0, 1'b1, 1'b0, 8'h10});
        @(negedge clk);
        check_val("t1_one_clk", {31'd0, write}, 32'd0);
        wait_strobes("t1_dstrobe_seen", 2, 1000);
        check_strobe("t1_seq", 1'b0, 1, 1'b1, 8'h55);
        check_val("t1_addr_gap", mon_q[1].tick - mon_q[0].tick, OPLL_ADDR_WAIT);
        wait_idle("t1_idle", 2000, fall);
        check_val("t1_data_gap", fall - mon_q[1].tick, OPLL_DATA_WAIT);
        check_val("t1_hold", {23'd0, addr, dout}, {23'd0, 1'b1, 8'h55});
        check_val("t1_count", mon_q.size(), 32'd2);

        // Same register twice: skipped address on dut, repeated on dut0
        do_reset();
        push(8'h30, 8'h11);
        push(8'h30, 8'h22);
        in_valid = 1'b0;
        wait_idle("t2_idle", 3000, fall);
        check_val("t2_count", mon_q.size(), 32'd3);
        check_strobe("t2_seq", 1'b0, 0, 1'b0, 8'h30);
        check_strobe("t2_seq", 1'b0, 1, 1'b1, 8'h11);
        check_strobe("t2_seq", 1'b0, 2, 1'b1, 8'h22);
        check_val("t2_skip_gap", mon_q[2].tick - mon_q[1].tick, OPLL_DATA_WAIT);
        check_val("t2_noskip_count", mon0_q.size(), 32'd4);
        check_strobe("t2_noskip", 1'b1, 0, 1'b0, 8'h30);
        check_strobe("t2_noskip", 1'b1, 1, 1'b1, 8'h11);
        check_strobe("t2_noskip", 1'b1, 2, 1'b0, 8'h30);
        check_strobe("t2_noskip", 1'b1, 3, 1'b1, 8'h22);

        // Burst of 6 into a 4-deep FIFO, cen every clk
        do_reset();
        cen_div = 1;
        for (int i = 0; i < 6; i++) push(8'(8'h20 + i), 8'(8'hA0 + i));
        in_valid = 1'b0;
        wait_idle("t3_idle", 3000, fall);
        check_val("t3_count", mon_q.size(), 32'd12);
        for (int i = 0; i < 6; i++) begin
            check_strobe("t3_seq", 1'b0, 2 * i, 1'b0, 8'(8'h20 + i));
            check_strobe("t3_seq", 1'b0, 2 * i + 1, 1'b1, 8'(8'hA0 + i));
        end
        check_val("t3_max_level", max_level, DEPTH);
        check_val("t3_saw_full", {31'd0, saw_full}, 32'd1);

        // Reset during AWAIT with 3 entries queued
        do_reset();
        cen_div = 4;
        push(8'h40, 8'h01);
        push(8'h41, 8'h02);
        push(8'h42, 8'h03);
        push(8'h43, 8'h04);
        in_valid = 1'b0;
        wait_strobes("t4_astrobe_seen", 1, 100);
        repeat (6) @(negedge clk);
        check_val("t4_level_pre", 32'(level), 32'd3);
        check_val("t4_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("t4_write_rst", {31'd0, write}, 32'd0);
        check_val("t4_level_rst", 32'(level), 32'd0);
        check_val("t4_busy_rst", {31'd0, busy}, 32'd0);
        check_val("t4_ready_rst", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
        mon0_q.delete();
        push(8'h40, 8'h77);
        in_valid = 1'b0;
        wait_idle("t4_idle", 2000, fall);
        check_val("t4_count", mon_q.size(), 32'd2);
        check_strobe("t4_seq", 1'b0, 0, 1'b0, 8'h40);
        check_strobe("t4_seq", 1'b0, 1, 1'b1, 8'h77);

        // cen held low for 500 clk inside DWAIT
        do_reset();
        push(8'h50, 8'h66);
        in_valid = 1'b0;
        wait_strobes("t5_dstrobe_seen", 2, 1000);
        repeat (40) @(negedge clk);
        cen_hold = 1'b1;
        repeat (500) @(negedge clk);
        check_val("t5_stall_count", mon_q.size(), 32'd2);
        check_val("t5_stall_busy", {31'd0, busy}, 32'd1);
        cen_hold = 1'b0;
        wait_idle("t5_idle", 2000, fall);
        check_val("t5_data_gap", fall - mon_q[1].tick, OPLL_DATA_WAIT);
        check_val("t5_count", mon_q.size(), 32'd2);

        // Push and pop together at level 2, then 20 entries through the wrap
        do_reset();
        cen_div = 1;
        for (int i = 0; i < 20; i++) vals[i] = 8'(i * 37 + 5);
        push(8'h60, vals[0]);
        push(8'h61, vals[1]);
        push(8'h62, vals[2]);
        in_valid = 1'b0;
        check_val("t6_level_pre", 32'(level), 32'd2);
        wait_strobes("t6_dstrobe_seen", 2, 200);
        c_d = mon_q[1].cyc;
        // DWAIT ends DATA_WAIT edges after the data strobe; IDLE pops one edge later.
        for (int k = 0; k < 200 && cyc != c_d + OPLL_DATA_WAIT; k++) @(negedge clk);
        check_val("t6_level_2", 32'(level), 32'd2);
        in_valid = 1'b1;
        in_reg   = 8'h63;
        in_val   = vals[3];
        @(negedge clk);
        in_valid = 1'b0;
        check_val("t6_level_same", 32'(level), 32'd2);
        check_val("t6_write_pop", {31'd0, write}, 32'd0);
        @(negedge clk);
        check_val("t6_astrobe", {23'd0, write, addr, dout}, {23'd0, 1'b1, 1'b0, 8'h61});
        for (int i = 4; i < 20; i++) push(8'(8'h60 + i), vals[i]);
        in_valid = 1'b0;
        wait_idle("t6_idle", 6000, fall);
        check_val("t6_count", mon_q.size(), 32'd40);
        for (int i = 0; i < 20; i++) begin
            check_strobe("t6_seq", 1'b0, 2 * i, 1'b0, 8'(8'h60 + i));
            check_strobe("t6_seq", 1'b0, 2 * i + 1, 1'b1, vals[i]);
        end

        check_val("ready_vs_level", rdy_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
